// File: rtl/ram_stream_reader.sv
// Streams a burst of words from an asynchronous-read RAM onto a valid/ready
// interface, with one output register and wrap-around addressing.
module ram_stream_reader #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int DEPTH_LOG = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DEPTH_LOG-1:0] start_addr,
    input  logic [DEPTH_LOG:0]   length,
    output logic [DEPTH_LOG-1:0] addr_rd,
    input  logic [WIDTH-1:0]     data_rd,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [DEPTH_LOG-1:0] addr_cnt;
    logic [DEPTH_LOG:0]   remaining;
    logic                 accept;
    logic                 load;
    logic                 last_load;

    always_comb begin
        accept     = out_valid & out_ready;
        load       = (state == READ) & (~out_valid | accept);
        last_load  = load & (remaining == (DEPTH_LOG+1)'(1));
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (length == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (last_load) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (accept) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start && (length != '0)) begin
                        addr_cnt  <= start_addr;
                        remaining <= length;
                    end
                end
                READ: begin
                    // A stalled beat keeps the register and the address frozen.
                    if (load) begin
                        out_data  <= data_rd;
                        out_valid <= 1'b1;
                        out_last  <= last_load;
                        addr_cnt  <= (addr_cnt == DEPTH_LOG'(DEPTH-1)) ? '0 : addr_cnt + 1'b1;
                        remaining <= remaining - 1'b1;
                    end
                end
                FLUSH: begin
                    if (accept) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign addr_rd = (state == IDLE) ? '0 : addr_cnt;
    assign busy    = (state == READ) || (state == FLUSH);
    assign done    = (state == DONE);

endmodule

// File: doc/ram_stream_reader.md
RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 8, RAM data word width.
REQ-002 SHALL have parameter DEPTH, default 16, number of RAM words.
REQ-003 SHALL have parameter DEPTH_LOG, default $clog2(DEPTH), RAM address width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  request a burst; sampled only in IDLE.
REQ-007 SHALL have port start_addr  input  DEPTH_LOG  first RAM address of the burst.
REQ-008 SHALL have port length  input  DEPTH_LOG+1  number of beats, 0..2*DEPTH-1.
REQ-009 SHALL have port addr_rd  output  DEPTH_LOG  read address to the RAM's asynchronous read port.
REQ-010 SHALL have port data_rd  input  WIDTH  RAM read data, combinationally valid for addr_rd.
REQ-011 SHALL have port out_data  output  WIDTH  stream data.
REQ-012 SHALL have port out_valid  output  1  stream data valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts beat.
REQ-014 SHALL have port out_last  output  1  marks the final beat of a burst.
REQ-015 SHALL have port busy  output  1  high from burst acceptance until done.
REQ-016 SHALL have port done  output  1  single-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, READ, FLUSH, DONE; busy high in READ and FLUSH.
REQ-018 In IDLE with start=1 and length!=0, SHALL latch start_addr into the address counter and length into the remaining counter, and go to READ.
REQ-019 In IDLE with start=1 and length=0, SHALL go to DONE with no beats emitted.
REQ-020 SHALL ignore start in every state except IDLE.
REQ-021 SHALL drive addr_rd from the address counter; addr_rd SHALL be 0 in IDLE.
REQ-022 A beat is accepted when out_valid=1 and out_ready=1 on a rising edge.
REQ-023 The output register SHALL be loadable when out_valid=0 or a beat is being accepted.
REQ-024 In READ, when loadable, SHALL capture data_rd into out_data, set out_valid=1, increment the address, and decrement remaining.
REQ-025 The address counter SHALL wrap from DEPTH-1 to 0.
REQ-026 SHALL set out_last=1 on the beat loaded when remaining=1, then go to FLUSH.
REQ-027 In FLUSH, on acceptance of the last beat, SHALL clear out_valid and out_last and go to DONE.
REQ-028 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-029 While out_valid=1 and out_ready=0, out_data, out_last, and addr_rd SHALL hold stable.
REQ-030 Latency: if start is sampled at edge E0, the first out_valid=1 SHALL appear after E1.
REQ-031 Throughput: with out_ready held high, SHALL emit one beat per cycle with no bubbles.
REQ-032 done SHALL assert the cycle after the last-beat acceptance edge.
REQ-033 No beat SHALL be dropped or duplicated under any out_ready pattern.

Reset
REQ-034 While rst=1 at a rising edge, SHALL enter IDLE regardless of state.
REQ-035 While rst=1 at a rising edge, out_valid, out_last, busy, and done SHALL be 0.
REQ-036 While rst=1 at a rising edge, out_data, addr_rd, the address counter, and the remaining counter SHALL be 0.
REQ-037 rst SHALL take priority over start.
REQ-038 A reset during a burst SHALL abort it with no done pulse.

Verification
REQ-039 The bench SHALL preload the RAM with ram[i]=i*8'h11 (0x00,0x11,...,0xFF).
REQ-040 Reset: assert rst 2 cycles -> all outputs 0, state IDLE.
REQ-041 start_addr=2, length=4, out_ready=1 -> out_data 0x22,0x33,0x44,0x55 on consecutive cycles, first one cycle after start; out_last only with 0x55; done pulses once the next cycle.
REQ-042 Wrap: start_addr=14, length=4 -> 0xEE,0xFF,0x00,0x11; addr_rd sequence 14,15,0,1.
REQ-043 Backpressure: start_addr=0, length=6, out_ready alternating 0/1 -> accepted beats exactly 0x00..0x55 in order, out_data stable while stalled.
REQ-044 length=0 with start -> out_valid never asserts, done pulses one cycle later; a start during busy is ignored (beat count unchanged).
REQ-045 rst=1 after 2 beats of a length=8 burst -> next cycle out_valid=0, busy=0, no done; a new burst start_addr=5, length=2 then yields 0x55,0x66.
